// File: rtl/prog_loader.sv
`timescale 1ns/1ps
// Program loader: packs a byte stream into 32-bit words, writes them to instruction RAM, then runs and dumps r0..r7.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (trailing 8-bit modular checksum byte after the in_last byte).
module prog_loader #(
  parameter int ADDR_W     = 9,
  parameter int RUN_CYCLES = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  output logic              wr,
  output logic [31:0]       wdata,
  output logic              working,
  output logic [3:0]        rID,
  output logic              dump_valid,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbgState
);

  // Handshake: a byte moves on a rising edge where in_valid && in_ready; in_ready is registered from the next state.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WRITE  = 3'd2,
    LOADED = 3'd3,
    RUN    = 3'd4,
    DUMP   = 3'd5,
    DONE   = 3'd6
`ifdef PROG_LOADER_CHECKSUM_EN
    , CHECK = 3'd7
`endif
  } state_t;

  localparam int RW = $clog2(RUN_CYCLES + 1);

  state_t          state, nextState;
  logic [1:0]      byteIdx;
  logic [31:0]     pack, packNext;
  logic            lastSeen;
  logic            chkBad;
  logic [RW-1:0]   runCnt;
  logic            accept, overflow;
  logic            inReadyNxt, wrNxt, workingNxt, dumpValidNxt, doneNxt;
  logic [3:0]      rIDNxt;

  assign accept   = in_valid && in_ready;
  assign overflow = word_count[ADDR_W];
  assign dbgState = state;

  // Merge the incoming byte into the word; the first byte of a word clears stale low bytes (zero padding).
  always_comb begin
    packNext = (byteIdx == 2'd0) ? 32'h0 : pack;
    case (byteIdx)
      2'd0:    packNext[31:24] = in_byte;
      2'd1:    packNext[23:16] = in_byte;
      2'd2:    packNext[15:8]  = in_byte;
      default: packNext[7:0]   = in_byte;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = in_last ? WRITE : LOAD;
      LOAD:    if (accept && (byteIdx == 2'd3 || in_last)) nextState = WRITE;
`ifdef PROG_LOADER_CHECKSUM_EN
      WRITE:   nextState = lastSeen ? CHECK : LOAD;
      CHECK:   if (accept) nextState = LOADED;
`else
      WRITE:   nextState = lastSeen ? LOADED : LOAD;
`endif
      LOADED:  if (start && word_count != '0 && !chkBad) nextState = RUN;
      RUN:     if (runCnt == RW'(RUN_CYCLES - 1)) nextState = DUMP;
      DUMP:    if (rID == 4'd7) nextState = DONE;
      DONE:    nextState = DONE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    inReadyNxt   = (nextState == IDLE) || (nextState == LOAD);
`ifdef PROG_LOADER_CHECKSUM_EN
    if (nextState == CHECK) inReadyNxt = 1'b1;
`endif
    wrNxt        = (nextState == WRITE) && (state != WRITE) && !overflow;
    workingNxt   = (nextState == RUN);
    dumpValidNxt = (nextState == DUMP);
    doneNxt      = (nextState == DONE);
    rIDNxt       = 4'hF;
    if (nextState == DUMP) rIDNxt = (state == DUMP) ? rID + 4'd1 : 4'd0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_ready   <= 1'b0;
      wr         <= 1'b0;
      working    <= 1'b0;
      dump_valid <= 1'b0;
      done       <= 1'b0;
      rID        <= 4'hF;
    end else begin
      in_ready   <= inReadyNxt;
      wr         <= wrNxt;
      working    <= workingNxt;
      dump_valid <= dumpValidNxt;
      done       <= doneNxt;
      rID        <= rIDNxt;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum    <= 8'h0;
      chkBad <= 1'b0;
    end else if (accept && (state == IDLE || state == LOAD)) begin
      sum <= sum + in_byte;
    end else if (accept && state == CHECK && in_byte != sum) begin
      chkBad <= 1'b1;
    end
  end
`else
  assign chkBad = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byteIdx    <= 2'd0;
      pack       <= 32'h0;
      lastSeen   <= 1'b0;
      wdata      <= 32'h0;
      addr       <= '0;
      word_count <= '0;
      err        <= 1'b0;
      runCnt     <= '0;
    end else begin
      if (accept && (state == IDLE || state == LOAD)) begin
        pack     <= packNext;
        byteIdx  <= byteIdx + 2'd1;
        lastSeen <= lastSeen | in_last;
        if (in_last && byteIdx != 2'd3) err <= 1'b1;
      end
      if (nextState == WRITE && state != WRITE) begin
        wdata <= packNext;
        if (overflow) err <= 1'b1;
      end
      if (state == WRITE) begin
        byteIdx <= 2'd0;
        if (!overflow) begin
          addr       <= addr + 1'b1;
          word_count <= word_count + 1'b1;
        end
      end
      if (nextState == RUN) addr <= '0;
      runCnt <= (state == RUN) ? runCnt + 1'b1 : '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      if (accept && state == CHECK && chkBad == 1'b0 && in_byte != sum) err <= 1'b1;
`endif
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Upstream boot/run controller for the pipelined processor. Accepts a program as a byte stream over a valid/ready handshake, packs bytes into 32-bit instruction words, and writes them into instruction RAM through the processor's `addr`/`wr`/`wdata` load port. On `start`, it asserts `working` for a fixed number of cycles. It then steps `rID` through r0..r7 so a downstream consumer can sample `rdata`.

## Interface
- `ADDR_W`, 9, instruction RAM address width; capacity 2^ADDR_W words.
- `RUN_CYCLES`, 32, number of cycles `working` is held high.
- `clock`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_byte` valid.
- `in_ready`  out  1  block accepts the byte this cycle.
- `in_byte`  in  8  program byte; first byte of a word is bits [31:24].
- `in_last`  in  1  qualifies the final program byte (with `in_valid`).
- `start`  in  1  single-cycle request to run the loaded program.
- `addr`  out  ADDR_W  RAM write address.
- `wr`  out  1  RAM write strobe.
- `wdata`  out  32  RAM write data.
- `working`  out  1  processor run enable.
- `rID`  out  4  register select for dump.
- `dump_valid`  out  1  `rID` holds a valid index 0..7.
- `word_count`  out  ADDR_W+1  words written since reset.
- `done`  out  1  run and dump complete.
- `err`  out  1  sticky error flag.

## Operation
- Reset values:
  - `in_ready`=0, `addr`=0, `wr`=0, `wdata`=0, `working`=0, `rID`=4'hF.
  - `dump_valid`=0, `word_count`=0, `done`=0, `err`=0.
  - State is IDLE.
- A byte is transferred when `in_valid` and `in_ready` are both high at a rising edge.
- `in_ready` is 1 only in IDLE and LOAD.
- States:
  - IDLE: waits for the first byte. On accept, goes to LOAD with byte index 1.
  - LOAD: shifts the byte into the packing register. When the 4th byte is accepted, goes to WRITE.
  - WRITE: exactly one cycle. `wr`=1; `wdata` holds the packed word; `addr` holds the current word address. On exit, `addr` increments and `word_count` increments. Next state is LOADED if `in_last` was seen, otherwise LOAD with byte index 0.
  - LOADED: ignores `in_valid`. When `start` is high, goes to RUN.
  - RUN: `working`=1 for exactly RUN_CYCLES cycles; `addr`=0. Then goes to DUMP.
  - DUMP: `working`=0. `rID` takes 0,1,...,7 on consecutive cycles with `dump_valid`=1. Then goes to DONE.
  - DONE: `done`=1 and `rID`=4'hF. Terminal until reset.
- Partial word: `in_last` on byte index 1..3 zero-pads the remaining low bytes, goes to WRITE, then LOADED, and sets `err`.
- Overflow: once `word_count` = 2^ADDR_W, later bytes are still accepted but dropped (no `wr`). `err` is set. `in_last` still moves to LOADED.
- `start` is ignored in IDLE, LOAD and WRITE, in DUMP and DONE, and in LOADED when `word_count`=0.
- `start` received while `err`=1 is still honoured, unless the checksum option below inhibits it.
- `wr` and `working` are never high in the same cycle.

## Timing
- The 4th byte accepted at edge N gives `wr`=1 during cycle N..N+1. The RAM captures the word at edge N+1.
- Peak load throughput: 4 bytes per 5 cycles.
- `start` sampled at edge S gives `working`=1 from S to S+RUN_CYCLES.
- `rID`=0 in the cycle after `working` falls.
- `done` rises 8 cycles after `working` falls.
- Outputs are registered; none depends combinationally on an input.
- `in_ready` is registered from state.
- Asserting `reset` mid-operation immediately clears `working` and `wr` (asynchronously). All other state returns to reset values, and the program must be reloaded.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - An 8-bit modular sum of all program bytes is accumulated.
  - After the `in_last` byte, the next accepted byte is the checksum; `in_ready` stays 1 for it. Then the state goes to LOADED.
  - On mismatch, `err` is set and `start` is ignored in LOADED.
- Not defined: there is no checksum byte, and the state goes to LOADED directly after the final WRITE.

## Test plan
- Load bytes 10 F0 00 80, 20 01 00 00 (`in_last` on the last byte):
  - two `wr` pulses: addr 0 data 32'h10F00080, then addr 1 data 32'h20010000;
  - `word_count`=2, `err`=0.
- Toggle `in_valid` every other cycle during a load: exactly one `wr` per 4 accepted bytes, data unchanged.
- After loading, pulse `start`:
  - `working` is high for exactly 32 cycles;
  - `rID` then steps 0..7 with `dump_valid`=1;
  - `done`=1 and `rID`=4'hF thereafter.
- `in_last` on the 2nd byte (AA BB): one write of 32'hAABB0000, `err`=1, state reaches LOADED.
- `start` before any load: ignored; `working` stays 0.
- Assert `reset` in the 10th RUN cycle: `working`=0 within that cycle, all outputs return to reset values, `start` is ignored until a new load.
